// File: rtl/sequence_encoder_pkg.sv
// Shared constants and types for the in-band line sequence encoder/detector.
// Frame layout: 8-bit identifier MSB-first, then 32-bit payload MSB-first,
// one bit per 36 samples (18 luma samples) across a 1440-sample active line.
package sequence_encoder_pkg;

    localparam int ID_BITS          = 8;
    localparam int PAYLOAD_BITS     = 32;
    localparam int TOTAL_BITS       = ID_BITS + PAYLOAD_BITS;
    localparam int SAMPLES_PER_LINE = 1440;
    localparam int SAMPLES_PER_BIT  = 36;

    localparam logic [9:0] BLACK_LEVEL_DEF    = 10'h040;
    localparam logic [9:0] WHITE_LEVEL_DEF    = 10'h3AC;
    localparam logic [9:0] CHROMA_NEUTRAL_DEF = 10'h200;

    // Receiver hysteresis midpoint, (black + white) >> 1 = 10'h1F6.
    localparam logic [10:0] LEVEL_SUM_DEF = {1'b0, BLACK_LEVEL_DEF} + {1'b0, WHITE_LEVEL_DEF};
    localparam logic [9:0]  HYST_MIDPOINT = 10'(LEVEL_SUM_DEF >> 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } enc_state_t;

    // Fixed line identifier sent ahead of every payload.
    function automatic logic [ID_BITS-1:0] identifier_const();
        return 8'hB4;
    endfunction

endpackage

// File: rtl/sequence_shiftreg_out.sv
// Parallel-load, MSB-out shift register feeding the line encoder.
// Load has priority over shift; reset_n clears asynchronously.
module sequence_shiftreg_out
    import sequence_encoder_pkg::*;
#(
    parameter int WIDTH = TOTAL_BITS
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load,
    input  logic             shift_en,
    input  logic [WIDTH-1:0] load_data,
    output logic             msb
);

    logic [WIDTH-1:0] sr_q;

    // Frame register: load a whole frame or move the next bit into the MSB.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sr_q <= '0;
        end else if (load) begin
            sr_q <= load_data;
        end else if (shift_en) begin
            sr_q <= {sr_q[WIDTH-2:0], 1'b0};
        end
    end

    assign msb = sr_q[WIDTH-1];

endmodule

// File: rtl/sequence_encoder.sv
// Line sequence encoder: writes one 40-bit frame onto an active video line,
// otherwise passes video through with one cycle of latency.
// Optional macro SEQUENCE_ENCODER_SOFT_EDGE_EN: drive the hysteresis midpoint on
// the first luma sample of a bit whose value differs from the previous bit.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// ST_IDLE | passthrough; a line_start with a pending word loads the frame
// ST_SEND | encoding samples 1..1439 of the line (sample 0 issued at load)
module sequence_encoder
    import sequence_encoder_pkg::*;
#(
    parameter logic [9:0] BLACK_LEVEL    = BLACK_LEVEL_DEF,
    parameter logic [9:0] WHITE_LEVEL    = WHITE_LEVEL_DEF,
    parameter logic [9:0] CHROMA_NEUTRAL = CHROMA_NEUTRAL_DEF
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic [9:0]              video_in,
    input  logic                    line_start,
    input  logic [PAYLOAD_BITS-1:0] sequence_in,
    input  logic                    sequence_valid,
    output logic                    sequence_ready,
    output logic [9:0]              video_out,
    output logic                    busy,
    output logic                    done
);

    localparam logic [10:0] LAST_SAMPLE = 11'(SAMPLES_PER_LINE - 1);
    localparam logic [5:0]  LAST_SUB    = 6'(SAMPLES_PER_BIT - 1);
    localparam logic [5:0]  LAST_BIT    = 6'(TOTAL_BITS - 1);

    enc_state_t              state_q, state_d;
    logic [10:0]             s_cnt_q;
    logic [5:0]              bit_cnt_q;
    logic [5:0]              sub_cnt_q;
    logic                    pend_full_q;
    logic [PAYLOAD_BITS-1:0] pend_q;
    logic                    last_q;
    logic [9:0]              video_q, video_d;
    logic                    busy_q, done_q;
    logic                    encoding;
    logic [9:0]              luma;

    logic accept, load, last_sample, shift_en, cur_bit;

    assign accept      = sequence_valid & ~pend_full_q;
    assign load        = (state_q == ST_IDLE) & line_start & pend_full_q;
    assign last_sample = (state_q == ST_SEND) && (s_cnt_q == LAST_SAMPLE);
    // The final bit never needs shifting out, so the register holds it to the end.
    assign shift_en    = (state_q == ST_SEND) && (sub_cnt_q == LAST_SUB) && (bit_cnt_q != LAST_BIT);

    assign sequence_ready = ~pend_full_q;

    // Pending slot: one word waiting for the next line; freed the moment it loads.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pend_full_q <= 1'b0;
            pend_q      <= '0;
        end else if (load) begin
            pend_full_q <= 1'b0;
        end else if (accept) begin
            pend_full_q <= 1'b1;
            pend_q      <= sequence_in;
        end
    end

    sequence_shiftreg_out #(
        .WIDTH (TOTAL_BITS)
    ) u_shiftreg (
        .clock     (clock),
        .reset_n   (reset_n),
        .load      (load),
        .shift_en  (shift_en),
        .load_data ({identifier_const(), pend_q}),
        .msb       (cur_bit)
    );

`ifdef SEQUENCE_ENCODER_SOFT_EDGE_EN
    localparam logic [10:0] LEVEL_SUM  = {1'b0, BLACK_LEVEL} + {1'b0, WHITE_LEVEL};
    localparam logic [9:0]  SOFT_LEVEL = 10'(LEVEL_SUM >> 1);

    logic prev_bit_q;

    // Remember the bit just finished so a value change can be softened.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            prev_bit_q <= 1'b0;
        end else if (shift_en) begin
            prev_bit_q <= cur_bit;
        end
    end
`endif

    // Luma level for the current bit, with the optional softened first sample.
    always_comb begin
        luma = cur_bit ? WHITE_LEVEL : BLACK_LEVEL;
`ifdef SEQUENCE_ENCODER_SOFT_EDGE_EN
        if ((sub_cnt_q == 6'd1) && (bit_cnt_q != 6'd0) && (cur_bit != prev_bit_q)) begin
            luma = SOFT_LEVEL;
        end
`endif
    end

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and the sample to register; sample 0 (chroma) goes out from the load cycle.
    always_comb begin
        state_d  = state_q;
        video_d  = video_in;
        encoding = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (load) begin
                    state_d  = ST_SEND;
                    video_d  = CHROMA_NEUTRAL;
                    encoding = 1'b1;
                end
            end
            ST_SEND: begin
                encoding = 1'b1;
                video_d  = s_cnt_q[0] ? luma : CHROMA_NEUTRAL;
                if (last_sample) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Sample, bit and sub-bit position within the encoded line.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s_cnt_q   <= '0;
            bit_cnt_q <= '0;
            sub_cnt_q <= '0;
        end else if (load) begin
            s_cnt_q   <= 11'd1;
            bit_cnt_q <= 6'd0;
            sub_cnt_q <= 6'd1;
        end else if (state_q == ST_SEND) begin
            if (last_sample) begin
                s_cnt_q   <= '0;
                bit_cnt_q <= '0;
                sub_cnt_q <= '0;
            end else begin
                s_cnt_q <= s_cnt_q + 11'd1;
                if (sub_cnt_q == LAST_SUB) begin
                    sub_cnt_q <= 6'd0;
                    bit_cnt_q <= bit_cnt_q + 6'd1;
                end else begin
                    sub_cnt_q <= sub_cnt_q + 6'd1;
                end
            end
        end
    end

    // Registered outputs; done trails the last encoded sample by one cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            video_q <= BLACK_LEVEL;
            busy_q  <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            video_q <= video_d;
            busy_q  <= encoding;
            last_q  <= last_sample;
            done_q  <= last_q;
        end
    end

    assign video_out = video_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
